// File: rtl/vec_acc_n_if.sv
// Stream bundle for vec_acc_n: input beats (s_*) and frame results (m_*).
// The slave modport is the accumulator's view; the master modport drives it.
interface vec_acc_n_if #(
    parameter int LANES = 6,
    parameter int IN_W  = 32,
    parameter int ACC_W = 48
) ();
    logic [LANES*IN_W-1:0]  s_data;
    logic                   s_valid;
    logic                   s_last;
    logic                   s_ready;
    logic [LANES*ACC_W-1:0] m_data;
    logic [15:0]            m_count;
    logic [LANES-1:0]       m_ovf;
    logic                   m_valid;
    logic                   m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_count, m_ovf, m_valid
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_count, m_ovf, m_valid
    );
endinterface

// File: rtl/vec_acc_n.sv
// Per-lane frame accumulator with one accumulator bank and one output bank.
// Optional macro VEC_ACC_SAT_EN: saturating lane adds with sticky per-lane overflow.
module vec_acc_n #(
    parameter int LANES = 6,
    parameter int IN_W  = 32,
    parameter int ACC_W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    vec_acc_n_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [LANES*ACC_W-1:0] acc_r, acc_nxt_s;
    logic [15:0]            cnt_r, cnt_nxt_s;
    logic [LANES-1:0]       aovf_r, aovf_nxt_s;
    logic [LANES*ACC_W-1:0] m_data_r, m_data_nxt_s;
    logic [15:0]            m_count_r, m_count_nxt_s;
    logic [LANES-1:0]       m_ovf_r, m_ovf_nxt_s;
    logic                   m_valid_r, m_valid_nxt_s;
    logic                   s_ready_r, s_ready_nxt_s;

    logic [LANES-1:0][ACC_W:0] add_s;
    logic [LANES*ACC_W-1:0]    sum_s;
    logic [LANES-1:0]          ovf_s;
    logic [15:0]               cnt_inc_s;
    logic                      accept_s;
    logic                      out_free_s;
    logic                      xfer_s;

    // Returns {overflow, sum}; overflow only ever reported when saturation is built in.
    function automatic logic [ACC_W:0] lane_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
        logic [ACC_W-1:0] sum;
        logic             ovf;
        sum = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);
`ifdef VEC_ACC_SAT_EN
        if (ovf) begin
            sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = sum;
        end
`else
        ovf = 1'b0;
`endif
        return {ovf, sum};
    endfunction

    assign accept_s   = bus.s_valid && s_ready_r;
    assign out_free_s = !m_valid_r || bus.m_ready;
    assign xfer_s     = m_valid_r && bus.m_ready;

    // Candidate accumulator contents if a beat is accepted this cycle (IDLE restarts from zero).
    always_comb begin
        add_s = '0;
        sum_s = '0;
        ovf_s = '0;
        for (int i = 0; i < LANES; i++) begin
            add_s[i] = lane_add((state_r == IDLE) ? {ACC_W{1'b0}} : acc_r[i*ACC_W +: ACC_W],
                                ACC_W'($signed(bus.s_data[i*IN_W +: IN_W])));
            sum_s[i*ACC_W +: ACC_W] = add_s[i][ACC_W-1:0];
            ovf_s[i] = add_s[i][ACC_W] | ((state_r == IDLE) ? 1'b0 : aovf_r[i]);
        end
        cnt_inc_s = (state_r == IDLE) ? 16'd1 :
                    ((cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1);
    end

    // Next-state and bank-update decisions.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        cnt_nxt_s     = cnt_r;
        aovf_nxt_s    = aovf_r;
        m_data_nxt_s  = m_data_r;
        m_count_nxt_s = m_count_r;
        m_ovf_nxt_s   = m_ovf_r;
        if (xfer_s) begin
            m_valid_nxt_s = 1'b0;
        end else begin
            m_valid_nxt_s = m_valid_r;
        end
        case (state_r)
            IDLE, ACC: begin
                if (accept_s) begin
                    if (bus.s_last && out_free_s) begin
                        m_data_nxt_s  = sum_s;
                        m_count_nxt_s = cnt_inc_s;
                        m_ovf_nxt_s   = ovf_s;
                        m_valid_nxt_s = 1'b1;
                        state_nxt_s   = IDLE;
                    end else if (bus.s_last) begin
                        acc_nxt_s   = sum_s;
                        cnt_nxt_s   = cnt_inc_s;
                        aovf_nxt_s  = ovf_s;
                        state_nxt_s = STALL;
                    end else begin
                        acc_nxt_s   = sum_s;
                        cnt_nxt_s   = cnt_inc_s;
                        aovf_nxt_s  = ovf_s;
                        state_nxt_s = ACC;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            STALL: begin
                // The output bank is always full here, so m_ready alone means a transfer.
                if (bus.m_ready) begin
                    m_data_nxt_s  = acc_r;
                    m_count_nxt_s = cnt_r;
                    m_ovf_nxt_s   = aovf_r;
                    m_valid_nxt_s = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = STALL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        s_ready_nxt_s = (state_nxt_s != STALL);
    end

    // State, accumulator bank and output bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            acc_r     <= '0;
            cnt_r     <= 16'd0;
            aovf_r    <= '0;
            m_data_r  <= '0;
            m_count_r <= 16'd0;
            m_ovf_r   <= '0;
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            aovf_r    <= aovf_nxt_s;
            m_data_r  <= m_data_nxt_s;
            m_count_r <= m_count_nxt_s;
            m_ovf_r   <= m_ovf_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            s_ready_r <= s_ready_nxt_s;
        end
    end

    assign bus.s_ready = s_ready_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_count = m_count_r;
    assign bus.m_ovf   = m_ovf_r;
    assign bus.m_valid = m_valid_r;
endmodule

// File: tb/tb_vec_acc_n.sv
// Scoreboard bench for vec_acc_n: default instance plus an 8-bit instance for wrap/saturation.
module tb_vec_acc_n;
    localparam int LANES = 6;
    localparam int IN_W  = 32;
    localparam int ACC_W = 48;
    localparam int W     = LANES * ACC_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vec_acc_n_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();
    vec_acc_n #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    vec_acc_n_if #(.LANES(2), .IN_W(8), .ACC_W(8)) bus8 ();
    vec_acc_n #(.LANES(2), .IN_W(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [W-1:0]     data;
        logic [15:0]      count;
        logic [LANES-1:0] ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] q8_data[$];
    logic [1:0]  q8_ovf[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LANES*IN_W-1:0] rep_in(input logic [IN_W-1:0] v);
        logic [LANES*IN_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] rep_acc(input logic [ACC_W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = v;
        return r;
    endfunction

    task automatic push(input logic [W-1:0] d, input logic [15:0] c, input logic [LANES-1:0] o);
        exp_t e;
        e.data = d;
        e.count = c;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic send(input logic [LANES*IN_W-1:0] d, input logic last);
        int n;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!bus.s_ready) begin
            errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Scoreboard monitor for the default instance.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", bus.m_data);
            end else begin
                mon_e = sb.pop_front();
                chk("m_data", bus.m_data, mon_e.data);
                chk("m_count", W'(bus.m_count), W'(mon_e.count));
                chk("m_ovf", W'(bus.m_ovf), W'(mon_e.ovf));
            end
        end
    end

    // Scoreboard monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n && bus8.m_valid && bus8.m_ready) begin
            if (q8_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result8: got %h expected none", bus8.m_data);
            end else begin
                chk("m_data8", W'(bus8.m_data), W'(q8_data.pop_front()));
                chk("m_ovf8", W'(bus8.m_ovf), W'(q8_ovf.pop_front()));
                chk("m_count8", W'(bus8.m_count), W'(16'd2));
            end
        end
    end

    initial begin
        logic [LANES*IN_W-1:0] d;
        logic [W-1:0]          e;
        int                    n;
        bus.s_data = '0;  bus.s_valid = 1'b0;  bus.s_last = 1'b0;  bus.m_ready = 1'b1;
        bus8.s_data = '0; bus8.s_valid = 1'b0; bus8.s_last = 1'b0; bus8.m_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", W'(bus.s_ready), W'(1'b0));
        chk("rst_m_valid", W'(bus.m_valid), W'(1'b0));
        chk("rst_m_data", bus.m_data, {W{1'b0}});
        chk("rst_m_count", W'(bus.m_count), W'(16'd0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Four-beat frame 1,2,3,4 -> 10 per lane, one cycle latency.
        push(rep_acc(48'd10), 16'd4, '0);
        send(rep_in(32'd1), 1'b0);
        send(rep_in(32'd2), 1'b0);
        send(rep_in(32'd3), 1'b0);
        send(rep_in(32'd4), 1'b1);
        chk("latency_m_valid", W'(bus.m_valid), W'(1'b1));
        repeat (2) @(posedge clk); #1;

        // Sign extension: lane0 -5 + 3, then single-beat lane5 0x80000000.
        e = '0; e[0 +: ACC_W] = 48'hFFFF_FFFF_FFFE;
        push(e, 16'd2, '0);
        d = '0; d[0 +: IN_W] = 32'hFFFF_FFFB;
        send(d, 1'b0);
        d = '0; d[0 +: IN_W] = 32'd3;
        send(d, 1'b1);
        e = '0; e[5*ACC_W +: ACC_W] = 48'hFFFF_8000_0000;
        push(e, 16'd1, '0);
        d = '0; d[5*IN_W +: IN_W] = 32'h8000_0000;
        send(d, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Back-pressure: A held in output bank, B stalls in accumulator bank.
        bus.m_ready = 1'b0;
        push(rep_acc(48'd14), 16'd2, '0);
        send(rep_in(32'd7), 1'b0);
        send(rep_in(32'd7), 1'b1);
        push(rep_acc(48'd3), 16'd3, '0);
        send(rep_in(32'd1), 1'b0);
        send(rep_in(32'd1), 1'b0);
        send(rep_in(32'd1), 1'b1);
        chk("stall_s_ready", W'(bus.s_ready), W'(1'b0));
        repeat (2) @(posedge clk); #1;
        chk("hold_m_valid", W'(bus.m_valid), W'(1'b1));
        chk("hold_m_data", bus.m_data, rep_acc(48'd14));
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("unstall_s_ready", W'(bus.s_ready), W'(1'b1));

        // Back-to-back single-beat frames.
        for (int k = 1; k <= 8; k++) begin
            chk("b2b_s_ready", W'(bus.s_ready), W'(1'b1));
            push(rep_acc(ACC_W'(k)), 16'd1, '0);
            send(rep_in(IN_W'(k)), 1'b1);
            chk("b2b_m_valid", W'(bus.m_valid), W'(1'b1));
        end
        repeat (2) @(posedge clk); #1;

        // 8-bit lanes: 100 + 100 wraps or saturates.
`ifdef VEC_ACC_SAT_EN
        q8_data.push_back(16'h7F7F);
        q8_ovf.push_back(2'b11);
`else
        q8_data.push_back(16'hC8C8);
        q8_ovf.push_back(2'b00);
`endif
        chk("s_ready8", W'(bus8.s_ready), W'(1'b1));
        bus8.s_data = {8'd100, 8'd100};
        bus8.s_valid = 1'b1;
        bus8.s_last = 1'b0;
        @(posedge clk); #1;
        bus8.s_last = 1'b1;
        @(posedge clk); #1;
        bus8.s_valid = 1'b0;
        bus8.s_last = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset mid-frame with a result pending: everything clears at once.
        bus.m_ready = 1'b0;
        push(rep_acc(48'd9), 16'd1, '0);
        send(rep_in(32'd9), 1'b1);
        send(rep_in(32'd5), 1'b0);
        send(rep_in(32'd5), 1'b0);
        chk("pre_rst_m_valid", W'(bus.m_valid), W'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", W'(bus.m_valid), W'(1'b0));
        chk("async_rst_m_data", bus.m_data, {W{1'b0}});
        chk("async_rst_m_count", W'(bus.m_count), W'(16'd0));
        chk("async_rst_s_ready", W'(bus.s_ready), W'(1'b0));
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        push(rep_acc(48'd3), 16'd3, '0);
        send(rep_in(32'd1), 1'b0);
        send(rep_in(32'd1), 1'b0);
        send(rep_in(32'd1), 1'b1);

        n = 0;
        while ((sb.size() != 0 || q8_data.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || q8_data.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size() + q8_data.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vec_acc_n.md
VEC_ACC_N -- requirements
Module: vec_acc_n

Interface
REQ-001 SHALL have parameter LANES, default 6, number of independent accumulation lanes (1..16).
REQ-002 SHALL have parameter IN_W, default 32, signed two's-complement input lane width.
REQ-003 SHALL have parameter ACC_W, default 48, signed accumulator/result lane width (ACC_W >= IN_W).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_data  input  LANES*IN_W  input vector; lane i at bits [i*IN_W +: IN_W].
REQ-007 s_valid  input  1  input beat valid.
REQ-008 s_last  input  1  marks final beat of a frame; qualified by s_valid.
REQ-009 s_ready  output  1  block can accept a beat.
REQ-010 m_data  output  LANES*ACC_W  frame result; lane i at bits [i*ACC_W +: ACC_W].
REQ-011 m_count  output  16  beats accepted in the reported frame, saturating at 16'hFFFF.
REQ-012 m_ovf  output  LANES  per-lane overflow flag for the reported frame.
REQ-013 m_valid  output  1  result valid.
REQ-014 m_ready  input  1  downstream accepts result.

Function
REQ-015 Beat accepted iff s_valid && s_ready; result transferred iff m_valid && m_ready.
REQ-016 SHALL hold an accumulator bank (LANES x ACC_W, beat counter, ovf bits) and one output bank driving m_data/m_count/m_ovf.
REQ-017 States: IDLE (no beat of current frame accepted), ACC (>=1 beat accepted), STALL (frame complete in accumulator bank, output bank occupied).
REQ-018 On accepted beat in IDLE: acc[i] <= sext(s_data lane i), count <= 1; in ACC: acc[i] <= acc[i] + sext(lane i), count <= count+1 (saturating).
REQ-019 Accepted beat with s_last=0: IDLE->ACC or ACC->ACC.
REQ-020 Accepted beat with s_last=1 and output bank free (!m_valid || m_ready) in that cycle: output bank <= final sums/count/ovf, m_valid=1 next cycle, state -> IDLE (latency 1 cycle last-beat to m_valid).
REQ-021 Accepted beat with s_last=1 and output bank occupied (m_valid && !m_ready): accumulator bank holds final sums, state -> STALL.
REQ-022 s_ready SHALL be 1 in IDLE and ACC, 0 in STALL; s_ready SHALL not depend on m_ready combinationally.
REQ-023 In STALL, on result transfer: output bank <= accumulator bank, m_valid stays 1, state -> IDLE, s_ready=1 next cycle.
REQ-024 A single-beat frame (s_last on first beat) SHALL produce m_count=1 and m_data = sign-extended beat.
REQ-025 Output bank contents and m_valid SHALL remain stable while m_valid && !m_ready.
REQ-026 On transfer with no new result ready, m_valid SHALL drop next cycle; back-to-back frames SHALL sustain one beat per cycle with no bubble when m_ready=1.

Reset
REQ-027 rst_n low SHALL immediately clear m_valid, m_data, m_count, m_ovf, accumulator bank and state to IDLE; s_ready SHALL be 0 while rst_n is low.
REQ-028 A frame in progress at reset SHALL be discarded; first accepted beat after deassertion starts a new frame.

Configuration
REQ-029 Macro VEC_ACC_SAT_EN defined: each lane add SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; lane ovf bit set sticky on any saturating add within the frame, reported with the frame, cleared at frame start.
REQ-030 Macro VEC_ACC_SAT_EN undefined: lane adds SHALL wrap modulo 2^ACC_W; m_ovf SHALL be tied to 0.

Verification
REQ-031 Defaults; 4-beat frame, all lanes 1,2,3,4, m_ready=1 -> one cycle after last beat m_valid=1, every lane 10, m_count=4.
REQ-032 Lane 0 beats -5 then 3 (last), lane 5 beat 32'h80000000 single-beat frame -> lane0 = -2 sign-extended to 48 bits; lane5 = 48'hFFFF80000000, m_count=1.
REQ-033 m_ready=0; frame A (2 beats, lanes 7) then frame B (3 beats, lanes 1) -> s_ready=0 after B's last; raise m_ready -> A (14,count 2) transfers, then B (3,count 3), s_ready=1 again.
REQ-034 Continuous 1-beat frames, value n on beat n, m_ready=1 -> s_ready stays 1, results n emitted every cycle, no loss.
REQ-035 ACC_W=IN_W=8, beats 100+100 -> with VEC_ACC_SAT_EN: 127, m_ovf all 1; without: -56, m_ovf=0.
REQ-036 rst_n pulsed low mid-frame after 2 beats of 5 -> m_valid=0 immediately; next 3-beat frame of 1s reports 3, count 3.
